// File: rtl/ifft_frame_sequencer.sv
// ---------------------------------------------------------------------------
// ifft_frame_sequencer
//
// Packs eight complex samples from an AXI-Stream sample port into one wide
// frame word and hands it to an IFFT core. Frames issued to the core but not
// yet retired are tracked with a credit count: each handshake takes one credit
// and each core_done pulse returns one. When no credit is left, the finished
// frame waits with m_axis_tvalid low.
//
// Ports
//   s_axis_aclk, s_axis_areset    clock, synchronous active-high reset
//   s_axis_t{valid,ready,data,last}   sample input (one complex sample/beat)
//   m_axis_t{valid,ready,data,last}   frame output (eight samples/beat)
//   core_done                     one-cycle credit return from the core
//   frame_err                     sticky: bad tlast position or stray core_done
//   frames_issued                 frames accepted by the core (wraps)
//   inflight                      frames outstanding in the core
// ---------------------------------------------------------------------------
module ifft_frame_sequencer #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_SAMPLE_WIDTH     = 64,
    parameter int C_MAX_INFLIGHT     = 4
) (
    input  logic                          s_axis_aclk,
    input  logic                          s_axis_areset,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [C_SAMPLE_WIDTH-1:0]     s_axis_tdata,
    input  logic                          s_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tlast,
    input  logic                          core_done,
    output logic                          frame_err,
    output logic [15:0]                   frames_issued,
    output logic [2:0]                    inflight
);

    localparam int         NSLOT  = 8;
    localparam logic [2:0] MAX_IF = 3'(C_MAX_INFLIGHT);

    typedef enum logic {FILL = 1'b0, ISSUE = 1'b1} state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [2:0]                      r_idx;
    logic [C_AXIS_TDATA_WIDTH-1:0]   r_buf;
    logic [C_AXIS_TDATA_WIDTH-1:0]   w_buf_nxt;
    logic                            r_tvalid;
    logic [2:0]                      r_inflight;
    logic [2:0]                      w_inflight_nxt;
    logic [15:0]                     r_issued;
    logic                            r_err;

    logic                            w_tready;
    logic                            w_accept;
    logic                            w_last_slot;
    logic                            w_frame_done;
    logic                            w_hs;
    logic                            w_done_ok;
    logic                            w_err_set;

    assign w_accept     = s_axis_tvalid & w_tready;
    assign w_last_slot  = (r_idx == 3'd7);
    assign w_frame_done = w_accept & (w_last_slot | s_axis_tlast);
    assign w_hs         = r_tvalid & m_axis_tready;
    // A credit return with nothing outstanding is not counted.
    assign w_done_ok    = core_done & (r_inflight != 3'd0);
    // tlast must coincide exactly with slot 7; either mismatch is an error.
    assign w_err_set    = (w_accept & (w_last_slot != s_axis_tlast))
                        | (core_done & (r_inflight == 3'd0));

    // State register
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (w_frame_done) w_state_nxt = ISSUE;
            ISSUE:   if (w_hs)         w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    // State-decoded outputs; tready is forced low while reset is asserted.
    always_comb begin
        w_tready = (r_state == FILL) && !s_axis_areset;
    end

    // Simultaneous handshake and valid credit return cancel out.
    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_hs && !w_done_ok) begin
            w_inflight_nxt = r_inflight + 3'd1;
        end else if (!w_hs && w_done_ok) begin
            w_inflight_nxt = r_inflight - 3'd1;
        end
    end

    // Write the accepted sample into its slot; an early tlast clears the
    // remaining higher slots so the frame is zero-padded.
    always_comb begin
        w_buf_nxt = r_buf;
        if (w_accept) begin
            for (int k = 0; k < NSLOT; k++) begin
                if (3'(k) == r_idx) begin
                    w_buf_nxt[k*C_SAMPLE_WIDTH +: C_SAMPLE_WIDTH] = s_axis_tdata;
                end else if (s_axis_tlast && (3'(k) > r_idx)) begin
                    w_buf_nxt[k*C_SAMPLE_WIDTH +: C_SAMPLE_WIDTH] = '0;
                end
            end
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            r_idx      <= 3'd0;
            r_buf      <= '0;
            r_tvalid   <= 1'b0;
            r_inflight <= 3'd0;
            r_issued   <= 16'd0;
            r_err      <= 1'b0;
        end else begin
            r_buf      <= w_buf_nxt;
            r_inflight <= w_inflight_nxt;
            if (w_accept) begin
                r_idx <= w_frame_done ? 3'd0 : r_idx + 3'd1;
            end
            // Registered so that in ISSUE tvalid tracks credit availability
            // one cycle after the count changes; a held frame cannot lose
            // tvalid because only the handshake consumes credit.
            r_tvalid <= (w_state_nxt == ISSUE) && (w_inflight_nxt < MAX_IF);
            if (w_hs) begin
                r_issued <= r_issued + 16'd1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign s_axis_tready = w_tready;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tvalid;
    assign m_axis_tdata  = r_buf;
    assign frame_err     = r_err;
    assign frames_issued = r_issued;
    assign inflight      = r_inflight;

endmodule

// File: doc/ifft_frame_sequencer.md
IFFT_FRAME_SEQUENCER -- requirements
Module: ifft_frame_sequencer

Interface
REQ-001 Parameter C_AXIS_TDATA_WIDTH, default 512; width of the packed frame word driven to the IFFT core.
REQ-002 Parameter C_SAMPLE_WIDTH, default 64; width of one complex sample, {real[63:32], imag[31:0]}, both signed.
REQ-003 Parameter C_MAX_INFLIGHT, default 4; maximum number of frames issued to the core and not yet retired.
REQ-004 The clock and reset ports SHALL be:
- s_axis_aclk, in, 1, the single clock for the block.
- s_axis_areset, in, 1, synchronous active-high reset.
REQ-005 The sample input ports SHALL be:
- s_axis_tvalid, in, 1, sample valid.
- s_axis_tready, out, 1, sample accept.
- s_axis_tdata, in, C_SAMPLE_WIDTH, complex sample.
- s_axis_tlast, in, 1, last sample of a frame.
REQ-006 The frame output ports to the IFFT core SHALL be:
- m_axis_tvalid, out, 1, frame valid.
- m_axis_tready, in, 1, frame accept from the core.
- m_axis_tdata, out, C_AXIS_TDATA_WIDTH, frame word with sample k in bits [64k+63:64k].
- m_axis_tlast, out, 1, frame delimiter.
REQ-007 Port core_done, in, 1, SHALL be a one-cycle pulse per frame result accepted downstream of the core (credit return).
REQ-008 The status output ports SHALL be:
- frame_err, out, 1, sticky framing/credit error flag.
- frames_issued, out, 16, count of frames accepted by the core.
- inflight, out, 3, count of outstanding frames.

Function
REQ-009 The FSM SHALL have two states: FILL (collect samples) and ISSUE (present the frame word).
REQ-010 In FILL, s_axis_tready SHALL be 1 and m_axis_tvalid SHALL be 0; in ISSUE, s_axis_tready SHALL be 0.
REQ-011 In FILL, each accepted sample SHALL be written to slot idx (3-bit counter starting at 0), and idx SHALL then increment.
REQ-012 Acceptance of the sample at idx=7 SHALL transition the FSM to ISSUE and reset idx to 0.
REQ-013 If the sample at idx=7 arrives with s_axis_tlast=0, frame_err SHALL be set, the frame SHALL still be issued, and the next sample SHALL start a new frame.
REQ-014 If s_axis_tlast=1 arrives at idx<7, slots idx+1..7 SHALL be zero-filled, frame_err SHALL be set, and the FSM SHALL go to ISSUE.
REQ-015 m_axis_tdata and m_axis_tvalid SHALL be registered, and m_axis_tvalid SHALL rise the cycle after the frame-completing sample is accepted (latency 1 cycle), provided inflight<C_MAX_INFLIGHT.
REQ-016 In ISSUE, m_axis_tvalid SHALL equal (inflight<C_MAX_INFLIGHT).
REQ-017 Once asserted, m_axis_tvalid SHALL stay asserted until accepted, and m_axis_tdata SHALL be stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-018 m_axis_tlast SHALL equal m_axis_tvalid.
REQ-019 On the handshake m_axis_tvalid&m_axis_tready:
- inflight SHALL increment.
- frames_issued SHALL increment, wrapping 0xFFFF->0.
- the FSM SHALL return to FILL on the next cycle.
REQ-020 core_done with inflight>0 SHALL decrement inflight.
REQ-021 A simultaneous handshake and core_done SHALL leave inflight unchanged.
REQ-022 core_done with inflight=0 SHALL be ignored for the count and SHALL set frame_err.
REQ-023 inflight SHALL never exceed C_MAX_INFLIGHT; at C_MAX_INFLIGHT, ISSUE SHALL hold with m_axis_tvalid=0 until a core_done arrives.
REQ-024 Sample data SHALL be passed through bit-exact; no arithmetic SHALL be performed on it.

Reset
REQ-025 On s_axis_areset=1 at a clock edge, the following SHALL be set:
- state=FILL, idx=0, inflight=0, frames_issued=0, frame_err=0.
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
- s_axis_tready=0 during the reset cycle.
REQ-026 A reset mid-frame or mid-ISSUE SHALL discard the partial or pending frame, with no handshake occurring in the reset cycle.
REQ-027 s_axis_tready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-028 Eight back-to-back samples 0x0000000100000000..0x0000000800000000 with tlast on the 8th and m_axis_tready=1 -> m_axis_tvalid high one cycle later; tdata slot k = (k+1)<<32; frames_issued=1; inflight=1.
REQ-029 tlast on the 3rd sample -> slots 3..7 = 0, frame_err=1, frame issued normally.
REQ-030 Five frames with core_done never asserted, C_MAX_INFLIGHT=4 -> 4 handshakes, 5th frame held with m_axis_tvalid=0; one core_done pulse -> 5th issued the next cycle, inflight stays 4.
REQ-031 m_axis_tready held 0 for 10 cycles during ISSUE -> m_axis_tvalid and tdata stable and s_axis_tready=0 throughout; handshake on release.
REQ-032 Handshake and core_done in the same cycle at inflight=2 -> inflight stays 2; core_done at inflight=0 -> frame_err=1, inflight stays 0.
REQ-033 Reset asserted after 5 samples -> idx=0 and all outputs at reset values; the next 8 samples form a clean frame with frame_err=0.
